// File: rtl/tetris_grid_pkg.sv
// Shared Tetris grid definitions: geometry, cell encoding and the
// row-clear sequencer state encoding. Used by the clear engine, the
// renderer and the piece logic.
package tetris_grid_pkg;

   // Grid geometry
   localparam int COLS    = 10;
   localparam int ROWS    = 20;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int CELLS   = ROWS * COLS;
   localparam int ROW_W   = $clog2(ROWS);
   localparam int COL_W   = $clog2(COLS);
   localparam int LINES_W = 5;

   // Cell value 0 means empty; any other value is a colour code
   localparam logic [DW-1:0] EMPTY_CELL = '0;

   // Row-clear sequencer states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SCAN_ADDR = 3'd1,
      SCAN_CHK  = 3'd2,
      SHIFT_RD  = 3'd3,
      SHIFT_WR  = 3'd4,
      CLEAR     = 3'd5,
      DONE      = 3'd6
   } clr_state_e;

endpackage

// File: rtl/grid_addr_gen.sv
// Linear cell address from (row, col): row*COLS + col, row 0 at the top.
// Purely combinational so the renderer can share it.
module grid_addr_gen
   import tetris_grid_pkg::*;
(
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   output logic [AW-1:0]    addr
);

   // Row-major address arithmetic
   always_comb begin
      addr = AW'(row) * AW'(COLS) + AW'(col);
   end

endmodule

// File: rtl/row_clear_engine.sv
// Line-clear sequencer. Owns grid RAM port A after a piece locks: scans
// rows bottom-up, and for every full row copies all rows above it down by
// one (bottom-up, so each source row is read before it is overwritten),
// blanks row 0 and rescans the same row. Reports the number of cleared
// lines at the end of the pass.
//
// Handshake: start is a one-cycle request honoured only in IDLE; busy is
// high while the pass runs (including the DONE cycle); done pulses for one
// cycle at the end; lines holds its value until the next accepted start.
// RAM reads have one cycle of latency: mem_rdata reflects the address
// presented in the previous cycle.
module row_clear_engine
   import tetris_grid_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [LINES_W-1:0] lines,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic               mem_we,
   input  logic [DW-1:0]      mem_rdata,
   output logic [2:0]         state_dbg
);

   localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [LINES_W-1:0] LINES_MAX = LINES_W'(ROWS);

   clr_state_e         state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;     // row being scanned
   logic [COL_W-1:0]   col_q, col_d;     // cell within the current row
   logic [ROW_W-1:0]   dst_q, dst_d;     // destination row of the shift
   logic [LINES_W-1:0] lines_q, lines_d;

   logic [ROW_W-1:0]   addr_row;
   logic [COL_W-1:0]   addr_col;

   // State and counter registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         dst_q   <= '0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         dst_q   <= dst_d;
         lines_q <= lines_d;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      dst_d   = dst_q;
      lines_d = lines_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               row_d   = ROW_LAST;
               col_d   = '0;
               lines_d = '0;
               state_d = SCAN_ADDR;
            end
         end
         SCAN_ADDR: begin
            state_d = SCAN_CHK;
         end
         SCAN_CHK: begin
            if (mem_rdata == EMPTY_CELL) begin
               // Row not full: move up, or finish after the top row
               if (row_q == '0) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q - 1'b1;
                  col_d   = '0;
                  state_d = SCAN_ADDR;
               end
            end else if (col_q != COL_LAST) begin
               col_d   = col_q + 1'b1;
               state_d = SCAN_ADDR;
            end else begin
               // Full row: shift everything above it down, or just blank row 0
               dst_d   = row_q;
               col_d   = '0;
               state_d = (row_q == '0) ? CLEAR : SHIFT_RD;
            end
         end
         SHIFT_RD: begin
            state_d = SHIFT_WR;
         end
         SHIFT_WR: begin
            if (col_q != COL_LAST) begin
               col_d   = col_q + 1'b1;
               state_d = SHIFT_RD;
            end else begin
               col_d   = '0;
               dst_d   = dst_q - 1'b1;
               state_d = (dst_q == ROW_W'(1)) ? CLEAR : SHIFT_RD;
            end
         end
         CLEAR: begin
            if (col_q != COL_LAST) begin
               col_d = col_q + 1'b1;
            end else begin
               // Row 0 blanked; rescan the same row since new content landed there
               col_d   = '0;
               state_d = SCAN_ADDR;
               if (lines_q != LINES_MAX) begin
                  lines_d = lines_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from state and counters
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      mem_we    = 1'b0;
      mem_wdata = EMPTY_CELL;
      addr_row  = '0;
      addr_col  = col_q;
      case (state_q)
         IDLE: begin
            addr_col = '0;
         end
         SCAN_ADDR, SCAN_CHK: begin
            addr_row = row_q;
         end
         SHIFT_RD: begin
            addr_row = dst_q - 1'b1;
         end
         SHIFT_WR: begin
            addr_row  = dst_q;
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
         end
         CLEAR: begin
            addr_row = '0;
            mem_we   = 1'b1;
         end
         default: begin
            addr_row = '0;
         end
      endcase
   end

   assign lines     = lines_q;
   assign state_dbg = state_q;

   grid_addr_gen u_addr (
      .row  (addr_row),
      .col  (addr_col),
      .addr (mem_addr)
   );

endmodule

// File: doc/row_clear_engine.md
# row_clear_engine

Line-clear sequencer for the Tetris grid. After a piece locks, it owns the write/read port A of the dual-port grid RAM. It scans rows bottom-up, detects full rows, shifts every row above down by one, and blanks the top row. Port B stays free for the renderer throughout. On completion it reports how many lines were cleared, which the scoring logic consumes.

## Interface
- COLS, 10, cells per row
- ROWS, 20, rows in grid; ROWS*COLS ≤ 2^AW
- AW, 8, grid RAM address width
- DW, 8, cell width; cell value 0 = empty, nonzero = occupied (colour code)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock, shared with grid RAM
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a clear pass
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of pass
- lines  out  5  rows cleared in the last pass (0..ROWS), held until next accepted start
- mem_addr  out  AW  to grid RAM addr_a; cell address = row*COLS + col, row 0 = top
- mem_wdata  out  DW  to grid RAM data_a
- mem_we  out  1  to grid RAM we_a
- mem_rdata  in  DW  from grid RAM q_a; valid the cycle after mem_addr is presented

## Operation
- States: IDLE, SCAN_ADDR, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLEAR, DONE.
- IDLE: start=1 → row=ROWS-1, col=0, lines=0, go to SCAN_ADDR. start while not IDLE is ignored.
- SCAN_ADDR: drive mem_addr=row*COLS+col, mem_we=0. Go to SCAN_CHK.
- SCAN_CHK: examine mem_rdata.
  - ==0: row not full. If row==0 → DONE; else row−1, col=0, go to SCAN_ADDR.
  - ≠0 and col<COLS-1: col+1, go to SCAN_ADDR.
  - ≠0 and col==COLS-1: row full. dst=row, col=0. If dst==0 → CLEAR, else → SHIFT_RD.
- SHIFT_RD: mem_addr=(dst−1)*COLS+col, we=0.
- SHIFT_WR: mem_addr=dst*COLS+col, mem_wdata=mem_rdata, we=1. Then:
  - col<COLS-1: col+1, go to SHIFT_RD.
  - col==COLS-1: col=0, dst−1. If new dst==0 → CLEAR, else → SHIFT_RD.
- CLEAR: mem_addr=col (row 0), mem_wdata=0, we=1, one cell per cycle. After col COLS-1: lines+1, col=0, rescan the same row (row unchanged), go to SCAN_ADDR.
- DONE: done=1 for one cycle, busy=0 next, return to IDLE.
- Outputs are combinational from state and counters. mem_we is high only in SHIFT_WR and CLEAR.
- lines saturates at ROWS. It can never exceed ROWS, because each clear inserts an empty top row.

## Timing
- Reset values: busy=0, done=0, lines=0, mem_addr=0, mem_wdata=0, mem_we=0, state=IDLE.
- Reset mid-pass: returns to IDLE immediately (async), mem_we drops at once. The grid may be left partially shifted; upstream must restart the pass.
- start is sampled at edge E. busy=1 from E. done=1 in the cycle when state==DONE.
- Scan cost is 2 cycles per cell read. A row stops at the first empty cell.
- Clearing row r costs:
  - 2*COLS scan cycles
  - plus 2*COLS*r shift cycles
  - plus COLS clear cycles
  - plus a rescan of row r.
- Empty grid: 2*ROWS scan cycles, so done is high 41 cycles after E (default params).
- Read-after-write hazard: none. Each shift reads row dst−1 before any write to it, because rows are copied bottom-up.

## Structure
- Shared package tetris_grid_pkg holds:
  - COLS, ROWS, AW, DW
  - the state enum
  - an empty-cell constant (0)
  - the grid geometry used by the renderer and piece logic.
- One sub-module: grid_addr_gen, combinational row*COLS+col → AW-bit address. It is reused by the renderer.
- The grid RAM is not instantiated here. Integration connects mem_* to port A.

## Test plan
- Empty grid, start → no mem_we activity; done 41 cycles after start; lines=0.
- Row 19 full (all cells=5), row 18 cell (18,3)=2, others 0 → lines=1; cell (19,3)=2, rest of row 19 =0; rows 0..18 all 0.
- Rows 19 and 17 full, row 18 has only col 0 = 7 → lines=2; row 19 = {7,0,…,0}; all other rows 0.
- Rows 16..19 full (Tetris), row 15 col 9 = 1 → lines=4; only (19,9)=1 nonzero.
- Only row 0 full → goes straight to CLEAR with no SHIFT states; row 0 all 0; lines=1.
- start pulsed again while busy → ignored, single done. rst_n asserted mid-SHIFT → mem_we=0 and busy=0 same cycle; then a new start runs a complete pass.
